// File: rtl/mm_cmd_sequencer.sv
// AXI4 memory-mapped master sequencer: turns CSR command pulses into one write and one read
// burst at a time, drives a counting write pattern and reports status and captured beats.
module mm_cmd_sequencer #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    aximm_wr,
  input  logic                    aximm_rd,
  input  logic [7:0]              aximm_rw_length,
  input  logic [1:0]              aximm_rw_burst,
  input  logic [2:0]              aximm_rw_size,
  input  logic [ADDR_WIDTH-1:0]   aximm_rw_addr,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic [7:0]              awlen,
  output logic [2:0]              awsize,
  output logic [1:0]              awburst,
  output logic                    wvalid,
  input  logic                    wready,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    wlast,
  input  logic                    bvalid,
  output logic                    bready,
  input  logic [1:0]              bresp,
  output logic                    arvalid,
  input  logic                    arready,
  output logic [ADDR_WIDTH-1:0]   araddr,
  output logic [7:0]              arlen,
  output logic [2:0]              arsize,
  output logic [1:0]              arburst,
  input  logic                    rvalid,
  output logic                    rready,
  input  logic [DATA_WIDTH-1:0]   rdata,
  input  logic [1:0]              rresp,
  input  logic                    rlast,
  output logic                    write_complete,
  output logic                    read_complete,
  output logic                    wr_busy,
  output logic                    rd_busy,
  output logic                    resp_error,
  output logic                    cmd_overrun,
  output logic [DATA_WIDTH-1:0]   data_out_first,
  output logic [DATA_WIDTH-1:0]   data_out_last,
  output logic                    data_out_first_valid,
  output logic                    data_out_last_valid,
  output logic [DATA_WIDTH-1:0]   data_in_first,
  output logic [DATA_WIDTH-1:0]   data_in_last,
  output logic                    data_in_first_valid,
  output logic                    data_in_last_valid
);

  localparam int unsigned Lanes = DATA_WIDTH / 32;

  typedef enum logic [1:0] {WIdle, WAddr, WData, WResp} w_state_e;
  typedef enum logic [1:0] {RIdle, RAddr, RData} r_state_e;

  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;

  logic                  awvalid_q, awvalid_d, wvalid_q, wvalid_d, wlast_q, wlast_d;
  logic                  bready_q, bready_d, arvalid_q, arvalid_d, rready_q, rready_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [7:0]            awlen_q, awlen_d, arlen_q, arlen_d;
  logic [2:0]            awsize_q, awsize_d, arsize_q, arsize_d;
  logic [1:0]            awburst_q, awburst_d, arburst_q, arburst_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [8:0]            w_beat_q, w_beat_d, r_beat_q, r_beat_d;
  logic [23:0]           pat_q, pat_d;
  logic                  wr_busy_q, wr_busy_d, rd_busy_q, rd_busy_d;
  logic                  wcomp_q, wcomp_d, rcomp_q, rcomp_d;
  logic                  resp_err_q, resp_err_d, overrun_q, overrun_d;
  logic [DATA_WIDTH-1:0] dof_q, dof_d, dol_q, dol_d, dif_q, dif_d, dil_q, dil_d;
  logic                  dofv_q, dofv_d, dolv_q, dolv_d, difv_q, difv_d, dilv_q, dilv_d;

  logic w_accept, r_accept, w_hs, r_hs, b_hs, b_err, r_err;

  // Each 32-bit lane carries its lane index above the shared 24-bit counter.
  function automatic logic [DATA_WIDTH-1:0] pattern(input logic [23:0] cnt);
    logic [DATA_WIDTH-1:0] res;
    res = '0;
    for (int i = 0; i < Lanes; i++) begin
      res[i*32 +: 32] = {8'(i), cnt};
    end
    return res;
  endfunction

  assign w_accept = aximm_wr && (w_state_q == WIdle);
  assign r_accept = aximm_rd && !aximm_wr && (r_state_q == RIdle);
  assign w_hs     = wvalid_q && wready;
  assign r_hs     = rready_q && rvalid;
  assign b_hs     = bready_q && bvalid;
  assign b_err    = b_hs && (bresp != 2'b00);
  assign r_err    = r_hs && ((rresp != 2'b00) ||
                             (rlast && (r_beat_q != {1'b0, arlen_q})) ||
                             (!rlast && (r_beat_q == {1'b0, arlen_q})));

  // Write engine
  always_comb begin
    w_state_d = w_state_q;
    awvalid_d = awvalid_q;
    awaddr_d  = awaddr_q;
    awlen_d   = awlen_q;
    awsize_d  = awsize_q;
    awburst_d = awburst_q;
    wvalid_d  = wvalid_q;
    wlast_d   = wlast_q;
    wdata_d   = wdata_q;
    bready_d  = bready_q;
    w_beat_d  = w_beat_q;
    pat_d     = pat_q;
    wr_busy_d = wr_busy_q;
    unique case (w_state_q)
      WIdle: begin
        if (aximm_wr) begin
          w_state_d = WAddr;
          awvalid_d = 1'b1;
          awaddr_d  = aximm_rw_addr;
          awlen_d   = aximm_rw_length;
          awsize_d  = aximm_rw_size;
          awburst_d = aximm_rw_burst;
          wr_busy_d = 1'b1;
        end
      end
      WAddr: begin
        if (awready) begin
          w_state_d = WData;
          awvalid_d = 1'b0;
          wvalid_d  = 1'b1;
          w_beat_d  = '0;
          wlast_d   = (awlen_q == 8'd0);
          wdata_d   = pattern(pat_q);
        end
      end
      WData: begin
        if (wready) begin
          pat_d   = pat_q + 24'd1;
          wdata_d = pattern(pat_q + 24'd1);
          if (wlast_q) begin
            w_state_d = WResp;
            wvalid_d  = 1'b0;
            wlast_d   = 1'b0;
            bready_d  = 1'b1;
          end else begin
            w_beat_d = w_beat_q + 9'd1;
            wlast_d  = ((w_beat_q + 9'd1) == {1'b0, awlen_q});
          end
        end
      end
      WResp: begin
        if (bvalid) begin
          w_state_d = WIdle;
          bready_d  = 1'b0;
          wr_busy_d = 1'b0;
        end
      end
      default: w_state_d = WIdle;
    endcase
  end

  // Read engine
  always_comb begin
    r_state_d = r_state_q;
    arvalid_d = arvalid_q;
    araddr_d  = araddr_q;
    arlen_d   = arlen_q;
    arsize_d  = arsize_q;
    arburst_d = arburst_q;
    rready_d  = rready_q;
    r_beat_d  = r_beat_q;
    rd_busy_d = rd_busy_q;
    unique case (r_state_q)
      RIdle: begin
        if (r_accept) begin
          r_state_d = RAddr;
          arvalid_d = 1'b1;
          araddr_d  = aximm_rw_addr;
          arlen_d   = aximm_rw_length;
          arsize_d  = aximm_rw_size;
          arburst_d = aximm_rw_burst;
          rd_busy_d = 1'b1;
        end
      end
      RAddr: begin
        if (arready) begin
          r_state_d = RData;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          r_beat_d  = '0;
        end
      end
      RData: begin
        if (rvalid) begin
          // Saturate rather than wrap when the slave overruns the burst length.
          if (r_beat_q != 9'h1ff) r_beat_d = r_beat_q + 9'd1;
          if (rlast) begin
            r_state_d = RIdle;
            rready_d  = 1'b0;
            rd_busy_d = 1'b0;
          end
        end
      end
      default: r_state_d = RIdle;
    endcase
  end

  // Status flags and beat capture
  always_comb begin
    wcomp_d    = wcomp_q;
    rcomp_d    = rcomp_q;
    resp_err_d = resp_err_q;
    overrun_d  = (aximm_wr && (w_state_q != WIdle)) ||
                 (aximm_rd && (aximm_wr || (r_state_q != RIdle)));
    if (w_accept) wcomp_d = 1'b0;
    else if (b_hs) wcomp_d = 1'b1;
    if (r_accept) rcomp_d = 1'b0;
    else if (r_hs && rlast) rcomp_d = 1'b1;
    if (w_accept || r_accept) resp_err_d = 1'b0;
    if (b_err || r_err) resp_err_d = 1'b1;
    dofv_d = w_hs && (w_beat_q == 9'd0);
    dolv_d = w_hs && wlast_q;
    difv_d = r_hs && (r_beat_q == 9'd0);
    dilv_d = r_hs && rlast;
    dof_d  = dofv_d ? wdata_q : dof_q;
    dol_d  = dolv_d ? wdata_q : dol_q;
    dif_d  = difv_d ? rdata : dif_q;
    dil_d  = dilv_d ? rdata : dil_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_q  <= WIdle;
      r_state_q  <= RIdle;
      awvalid_q  <= 1'b0;
      awaddr_q   <= '0;
      awlen_q    <= '0;
      awsize_q   <= '0;
      awburst_q  <= '0;
      wvalid_q   <= 1'b0;
      wlast_q    <= 1'b0;
      wdata_q    <= '0;
      bready_q   <= 1'b0;
      w_beat_q   <= '0;
      pat_q      <= '0;
      wr_busy_q  <= 1'b0;
      arvalid_q  <= 1'b0;
      araddr_q   <= '0;
      arlen_q    <= '0;
      arsize_q   <= '0;
      arburst_q  <= '0;
      rready_q   <= 1'b0;
      r_beat_q   <= '0;
      rd_busy_q  <= 1'b0;
      wcomp_q    <= 1'b0;
      rcomp_q    <= 1'b0;
      resp_err_q <= 1'b0;
      overrun_q  <= 1'b0;
      dof_q      <= '0;
      dol_q      <= '0;
      dif_q      <= '0;
      dil_q      <= '0;
      dofv_q     <= 1'b0;
      dolv_q     <= 1'b0;
      difv_q     <= 1'b0;
      dilv_q     <= 1'b0;
    end else begin
      w_state_q  <= w_state_d;
      r_state_q  <= r_state_d;
      awvalid_q  <= awvalid_d;
      awaddr_q   <= awaddr_d;
      awlen_q    <= awlen_d;
      awsize_q   <= awsize_d;
      awburst_q  <= awburst_d;
      wvalid_q   <= wvalid_d;
      wlast_q    <= wlast_d;
      wdata_q    <= wdata_d;
      bready_q   <= bready_d;
      w_beat_q   <= w_beat_d;
      pat_q      <= pat_d;
      wr_busy_q  <= wr_busy_d;
      arvalid_q  <= arvalid_d;
      araddr_q   <= araddr_d;
      arlen_q    <= arlen_d;
      arsize_q   <= arsize_d;
      arburst_q  <= arburst_d;
      rready_q   <= rready_d;
      r_beat_q   <= r_beat_d;
      rd_busy_q  <= rd_busy_d;
      wcomp_q    <= wcomp_d;
      rcomp_q    <= rcomp_d;
      resp_err_q <= resp_err_d;
      overrun_q  <= overrun_d;
      dof_q      <= dof_d;
      dol_q      <= dol_d;
      dif_q      <= dif_d;
      dil_q      <= dil_d;
      dofv_q     <= dofv_d;
      dolv_q     <= dolv_d;
      difv_q     <= difv_d;
      dilv_q     <= dilv_d;
    end
  end

  assign awvalid              = awvalid_q;
  assign awaddr               = awaddr_q;
  assign awlen                = awlen_q;
  assign awsize               = awsize_q;
  assign awburst              = awburst_q;
  assign wvalid               = wvalid_q;
  assign wdata                = wdata_q;
  assign wstrb                = '1;
  assign wlast                = wlast_q;
  assign bready               = bready_q;
  assign arvalid              = arvalid_q;
  assign araddr               = araddr_q;
  assign arlen                = arlen_q;
  assign arsize               = arsize_q;
  assign arburst              = arburst_q;
  assign rready               = rready_q;
  assign write_complete       = wcomp_q;
  assign read_complete        = rcomp_q;
  assign wr_busy              = wr_busy_q;
  assign rd_busy              = rd_busy_q;
  assign resp_error           = resp_err_q;
  assign cmd_overrun          = overrun_q;
  assign data_out_first       = dof_q;
  assign data_out_last        = dol_q;
  assign data_out_first_valid = dofv_q;
  assign data_out_last_valid  = dolv_q;
  assign data_in_first        = dif_q;
  assign data_in_last         = dil_q;
  assign data_in_first_valid  = difv_q;
  assign data_in_last_valid   = dilv_q;

endmodule

// File: tb/tb_mm_cmd_sequencer.sv
// Directed bench for mm_cmd_sequencer: expected W beats are queued when a write is issued
// and checked by a monitor as the DUT presents them; status and captures checked inline.
module tb_mm_cmd_sequencer;
  localparam int DW = 64;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          aximm_wr = 1'b0, aximm_rd = 1'b0;
  logic [7:0]    aximm_rw_length = '0;
  logic [1:0]    aximm_rw_burst = '0;
  logic [2:0]    aximm_rw_size = '0;
  logic [AW-1:0] aximm_rw_addr = '0;
  logic          awvalid, awready = 1'b0;
  logic [AW-1:0] awaddr, araddr;
  logic [7:0]    awlen, arlen;
  logic [2:0]    awsize, arsize;
  logic [1:0]    awburst, arburst;
  logic          wvalid, wready = 1'b0, wlast;
  logic [DW-1:0] wdata;
  logic [DW/8-1:0] wstrb;
  logic          bvalid = 1'b0, bready;
  logic [1:0]    bresp = '0;
  logic          arvalid, arready = 1'b0;
  logic          rvalid = 1'b0, rready, rlast = 1'b0;
  logic [DW-1:0] rdata = '0;
  logic [1:0]    rresp = '0;
  logic          write_complete, read_complete, wr_busy, rd_busy, resp_error, cmd_overrun;
  logic [DW-1:0] data_out_first, data_out_last, data_in_first, data_in_last;
  logic          data_out_first_valid, data_out_last_valid;
  logic          data_in_first_valid, data_in_last_valid;

  int n_assert = 0;
  int n_fail = 0;
  logic [DW:0] wq[$];
  logic [23:0] exp_pat = '0;

  always #5 clk = ~clk;

  mm_cmd_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .aximm_wr(aximm_wr), .aximm_rd(aximm_rd), .aximm_rw_length(aximm_rw_length),
    .aximm_rw_burst(aximm_rw_burst), .aximm_rw_size(aximm_rw_size),
    .aximm_rw_addr(aximm_rw_addr),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .write_complete(write_complete), .read_complete(read_complete),
    .wr_busy(wr_busy), .rd_busy(rd_busy), .resp_error(resp_error), .cmd_overrun(cmd_overrun),
    .data_out_first(data_out_first), .data_out_last(data_out_last),
    .data_out_first_valid(data_out_first_valid), .data_out_last_valid(data_out_last_valid),
    .data_in_first(data_in_first), .data_in_last(data_in_last),
    .data_in_first_valid(data_in_first_valid), .data_in_last_valid(data_in_last_valid)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat_word(input logic [23:0] cnt);
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = {8'(i), cnt};
    return r;
  endfunction

  task automatic push_write(input int len);
    for (int b = 0; b <= len; b++) begin
      wq.push_back({(b == len), pat_word(exp_pat)});
      exp_pat++;
    end
  endtask

  // W channel monitor: each handshake pops one expected beat.
  always @(negedge clk) begin
    if (rst_n && wvalid && wready) begin
      if (wq.size() == 0) begin
        check("w_unexpected_beat", 64'(wvalid), 64'd0);
      end else begin
        logic [DW:0] e;
        e = wq.pop_front();
        check("wdata", wdata, e[DW-1:0]);
        check("wlast", 64'(wlast), 64'(e[DW]));
        check("wstrb", 64'(wstrb), 64'hff);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input bit wr, input bit rd, input logic [7:0] len,
                          input logic [AW-1:0] addr);
    aximm_wr = wr; aximm_rd = rd;
    aximm_rw_length = len; aximm_rw_addr = addr;
    aximm_rw_burst = 2'd1; aximm_rw_size = 3'd3;
    tick();
    aximm_wr = 1'b0; aximm_rd = 1'b0;
    aximm_rw_length = 8'hee; aximm_rw_addr = 32'hdead_beef;
    aximm_rw_burst = 2'd3; aximm_rw_size = 3'd7;
  endtask

  task automatic serve_write(input bit aw_done_in, input int aw_delay, input logic [1:0] br,
                             input int len);
    bit aw_done, early, done, hs_aw, hs_wl, hs_b;
    int waited;
    aw_done = aw_done_in; early = 0; done = 0; waited = 0;
    wready = 1'b1;
    for (int g = 0; g < 200 && !done; g++) begin
      awready = (waited >= aw_delay);
      if (wvalid && !aw_done) early = 1;
      bvalid = bready;
      bresp = bready ? br : 2'b00;
      hs_aw = awvalid && awready;
      hs_wl = wvalid && wready && wlast;
      hs_b  = bvalid && bready;
      tick();
      waited++;
      if (hs_aw) aw_done = 1;
      if (hs_wl) begin
        check("out_last_valid", 64'(data_out_last_valid), 64'd1);
        check("out_first_valid", 64'(data_out_first_valid), 64'(len == 0));
      end
      if (hs_b) begin
        done = 1;
        bvalid = 1'b0; bresp = 2'b00; awready = 1'b0; wready = 1'b0;
        check("write_complete", 64'(write_complete), 64'd1);
        check("wr_busy_after_b", 64'(wr_busy), 64'd0);
      end
    end
    check("write_finished", 64'(done), 64'd1);
    check("w_before_aw", 64'(early), 64'd0);
  endtask

  task automatic serve_read(input int last_idx, input bit toggle,
                            output logic [DW-1:0] first, output logic [DW-1:0] last);
    bit ar_done, done, hs_ar, hs_r;
    int beat;
    ar_done = 0; done = 0; beat = 0; first = '0; last = '0;
    arready = 1'b1;
    for (int g = 0; g < 300 && !done; g++) begin
      if (ar_done) begin
        rvalid = toggle ? g[0] : 1'b1;
        rdata  = {$urandom, $urandom};
        rlast  = (beat == last_idx);
        rresp  = 2'b00;
      end
      hs_ar = arvalid && arready;
      hs_r  = rvalid && rready;
      tick();
      if (hs_ar) begin ar_done = 1; arready = 1'b0; end
      if (hs_r) begin
        if (beat == 0) first = rdata;
        if (rlast) begin
          last = rdata; done = 1;
          rvalid = 1'b0; rlast = 1'b0;
          check("read_complete", 64'(read_complete), 64'd1);
          check("in_last_valid", 64'(data_in_last_valid), 64'd1);
          check("rd_busy_after_rlast", 64'(rd_busy), 64'd0);
        end
        beat++;
      end
    end
    check("read_finished", 64'(done), 64'd1);
    check("read_beats", 64'(beat), 64'(last_idx + 1));
  endtask

  initial begin
    logic [DW-1:0] f, l;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_awvalid", 64'(awvalid), 64'd0);
    check("rst_wvalid", 64'(wvalid), 64'd0);
    check("rst_arvalid", 64'(arvalid), 64'd0);
    check("rst_readys", 64'({bready, rready, wlast}), 64'd0);
    check("rst_flags", 64'({write_complete, read_complete, wr_busy, rd_busy, resp_error,
                            cmd_overrun}), 64'd0);
    check("rst_wdata", wdata, 64'd0);
    check("rst_awaddr", 64'(awaddr), 64'd0);
    check("rst_dout_first", data_out_first, 64'd0);

    // Write len=3, always ready
    push_write(3);
    send_cmd(1, 0, 8'd3, 32'h0000_1000);
    check("t1_awvalid", 64'(awvalid), 64'd1);
    check("t1_awaddr", 64'(awaddr), 64'h1000);
    check("t1_awlen", 64'(awlen), 64'd3);
    check("t1_awsize_burst", 64'({awsize, awburst}), 64'({3'd3, 2'd1}));
    check("t1_wvalid_early", 64'(wvalid), 64'd0);
    check("t1_wr_busy", 64'(wr_busy), 64'd1);
    serve_write(0, 0, 2'b00, 3);
    check("t1_dout_first", data_out_first, 64'h0100_0000_0000_0000);
    check("t1_dout_last_lane1", 64'(data_out_last[63:32]), 64'h0100_0003);
    check("t1_resp_error", 64'(resp_error), 64'd0);

    // Read len=7, rvalid toggling
    send_cmd(0, 1, 8'd7, 32'h0000_2000);
    check("t2_arvalid", 64'(arvalid), 64'd1);
    check("t2_araddr", 64'(araddr), 64'h2000);
    check("t2_arlen", 64'(arlen), 64'd7);
    serve_read(7, 1, f, l);
    check("t2_din_first", data_in_first, f);
    check("t2_din_last", data_in_last, l);
    check("t2_resp_error", 64'(resp_error), 64'd0);

    // Simultaneous wr+rd, then wr during W_DATA
    push_write(2);
    send_cmd(1, 1, 8'd2, 32'h0000_3000);
    check("t3_overrun1", 64'(cmd_overrun), 64'd1);
    check("t3_awvalid", 64'(awvalid), 64'd1);
    check("t3_no_ar", 64'(arvalid), 64'd0);
    awready = 1'b1; wready = 1'b0;
    tick();
    awready = 1'b0;
    check("t3_overrun_pulse", 64'(cmd_overrun), 64'd0);
    check("t3_wvalid", 64'(wvalid), 64'd1);
    send_cmd(1, 0, 8'd9, 32'h0000_4000);
    check("t3_overrun2", 64'(cmd_overrun), 64'd1);
    check("t3_awaddr_kept", 64'(awaddr), 64'h3000);
    check("t3_awlen_kept", 64'(awlen), 64'd2);
    serve_write(1, 0, 2'b00, 2);
    check("t3_no_read", 64'({arvalid, rd_busy}), 64'd0);
    check("t3_read_complete_kept", 64'(read_complete), 64'd1);

    // len=0 write, AW delayed, SLVERR
    push_write(0);
    send_cmd(1, 0, 8'd0, 32'h0000_5000);
    serve_write(0, 5, 2'b10, 0);
    check("t4_resp_error", 64'(resp_error), 64'd1);

    // Read len=3, rlast early on beat 2
    send_cmd(0, 1, 8'd3, 32'h0000_6000);
    check("t5_resp_error_cleared", 64'(resp_error), 64'd0);
    check("t5_read_complete_cleared", 64'(read_complete), 64'd0);
    serve_read(2, 0, f, l);
    check("t5_resp_error", 64'(resp_error), 64'd1);
    check("t5_din_last", data_in_last, l);

    // Asynchronous reset in W_DATA
    push_write(3);
    send_cmd(1, 0, 8'd3, 32'h0000_7000);
    awready = 1'b1; wready = 1'b0;
    tick();
    awready = 1'b0;
    check("t6_wvalid_before_rst", 64'(wvalid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_valids", 64'({awvalid, wvalid, arvalid, bready, rready, wlast}), 64'd0);
    check("t6_rst_busy", 64'({wr_busy, rd_busy}), 64'd0);
    wq.delete();
    exp_pat = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    push_write(1);
    send_cmd(1, 0, 8'd1, 32'h0000_8000);
    serve_write(0, 0, 2'b00, 1);
    check("t6_dout_first", data_out_first, pat_word(24'd0));
    check("t6_queue_empty", 64'(wq.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
